regfile_2r1w_param: RTL

- Parameterised register file: one write port, two independent registered read ports, each with its own read-address stall.
- Entry 0 optionally hardwired to zero.
- Synchronous clear sequencer zeroes the whole array one entry per cycle, so the CPU can flush architectural state without a reset.
- Replaces the single-read-port register RAM in the CPU decode/operand-fetch stage.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_2r1w_param_if.sv | 18 +
 rtl/regfile_rd_port.sv | 45 ++++
 rtl/regfile_2r1w_param.sv | 69 ++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, constants and width helper for the 2R1W register file
package regfile_pkg;
   typedef enum logic {RF_IDLE, RF_CLEARING} rf_state_t;
   localparam int RF_ZERO_ADDR = 0;
   function automatic int rf_q_width(input int data_width);
      return (data_width > 0) ? data_width : 1;
   endfunction
endpackage

// File: rtl/regfile_2r1w_param_if.sv
// regfile_2r1w_param_if: write/read/clear bus of the register file; master = issuing stage, slave = register file
interface regfile_2r1w_param_if #(parameter int ADDR_WIDTH = 3, parameter int DATA_WIDTH = 16);
   logic                  wren;
   logic [ADDR_WIDTH-1:0] wraddress;
   logic [DATA_WIDTH-1:0] data;
   logic [ADDR_WIDTH-1:0] rdaddress_a;
   logic [ADDR_WIDTH-1:0] rdaddress_b;
   logic                  rd_addressstall_a;
   logic                  rd_addressstall_b;
   logic [DATA_WIDTH-1:0] q_a;
   logic [DATA_WIDTH-1:0] q_b;
   logic                  clear;
   logic                  busy;
   modport master (output wren, wraddress, data, rdaddress_a, rdaddress_b, rd_addressstall_a,
                   rd_addressstall_b, clear, input q_a, q_b, busy);
   modport slave  (input wren, wraddress, data, rdaddress_a, rdaddress_b, rd_addressstall_a,
                   rd_addressstall_b, clear, output q_a, q_b, busy);
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port (stall buffer, effective-address mux, output register, bypass under REGFILE_WRITE_BYPASS_EN); ports: clock, reset (async low), i_addr, i_stall, i_mem_data, [i_wr_en/i_wr_addr/i_wr_data], o_eff_addr, o_q
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ZERO_REG   = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [ADDR_WIDTH-1:0]             i_addr,
   input  logic                              i_stall,
   input  logic [DATA_WIDTH-1:0]             i_mem_data,
`ifdef REGFILE_WRITE_BYPASS_EN
   input  logic                              i_wr_en,
   input  logic [ADDR_WIDTH-1:0]             i_wr_addr,
   input  logic [DATA_WIDTH-1:0]             i_wr_data,
`endif
   output logic [ADDR_WIDTH-1:0]             o_eff_addr,
   output logic [rf_q_width(DATA_WIDTH)-1:0] o_q
);
   logic [ADDR_WIDTH-1:0] r_addr_buf, w_eff;
   logic [DATA_WIDTH-1:0] w_rd, r_q;
   always_comb begin
      w_eff = i_stall ? r_addr_buf : i_addr;
`ifdef REGFILE_WRITE_BYPASS_EN
      // i_wr_en is already qualified (IDLE, not a discarded zero-register write)
      w_rd = (i_wr_en && i_wr_addr == w_eff) ? i_wr_data : i_mem_data;
`else
      w_rd = i_mem_data;
`endif
      w_rd = (ZERO_REG != 0 && w_eff == ADDR_WIDTH'(RF_ZERO_ADDR)) ? '0 : w_rd;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_addr_buf <= '0;
         r_q        <= '0;
      end else begin
         r_addr_buf <= w_eff;
         r_q        <= w_rd;
      end
   end
   assign o_eff_addr = w_eff;
   assign o_q        = r_q;
endmodule

// File: rtl/regfile_2r1w_param.sv
// regfile_2r1w_param: 2-read/1-write register file with optional zero entry and a one-entry-per-cycle clear sweep; ports: clock, reset (async low), bus (slave: write port, two stallable read ports, clear/busy); optional macro REGFILE_WRITE_BYPASS_EN
module regfile_2r1w_param
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ZERO_REG   = 1
) (
   input logic                  clock,
   input logic                  reset,
   regfile_2r1w_param_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   rf_state_t             r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr, w_eff_a, w_eff_b;
   logic                  w_wr_ok;
   always_comb begin
      w_wr_ok     = bus.wren && r_state == RF_IDLE &&
                    !(ZERO_REG != 0 && bus.wraddress == ADDR_WIDTH'(RF_ZERO_ADDR));
      w_state_nxt = (r_state == RF_IDLE) ? (bus.clear ? RF_CLEARING : RF_IDLE)
                                         : ((r_ptr == '1) ? RF_IDLE : RF_CLEARING);
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_state <= RF_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == RF_CLEARING) begin
            r_mem[r_ptr] <= '0;
            r_ptr        <= r_ptr + 1'b1;
         end else begin
            r_ptr <= '0;
            if (w_wr_ok) r_mem[bus.wraddress] <= bus.data;
         end
      end
   end
   assign bus.busy = (r_state == RF_CLEARING);
   regfile_rd_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ZERO_REG(ZERO_REG)) u_rd_a (
      .clock      (clock),
      .reset      (reset),
      .i_addr     (bus.rdaddress_a),
      .i_stall    (bus.rd_addressstall_a),
      .i_mem_data (r_mem[w_eff_a]),
`ifdef REGFILE_WRITE_BYPASS_EN
      .i_wr_en    (w_wr_ok),
      .i_wr_addr  (bus.wraddress),
      .i_wr_data  (bus.data),
`endif
      .o_eff_addr (w_eff_a),
      .o_q        (bus.q_a)
   );
   regfile_rd_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ZERO_REG(ZERO_REG)) u_rd_b (
      .clock      (clock),
      .reset      (reset),
      .i_addr     (bus.rdaddress_b),
      .i_stall    (bus.rd_addressstall_b),
      .i_mem_data (r_mem[w_eff_b]),
`ifdef REGFILE_WRITE_BYPASS_EN
      .i_wr_en    (w_wr_ok),
      .i_wr_addr  (bus.wraddress),
      .i_wr_data  (bus.data),
`endif
      .o_eff_addr (w_eff_b),
      .o_q        (bus.q_b)
   );
endmodule
